// File: rtl/axis_pkt_echo_if.sv
// AXI-stream bundle for axis_pkt_echo: valid/ready handshake plus data, byte keep and last.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface axis_pkt_echo_if #(
    parameter int DATA_W = 16
);
    localparam int KEEP_W = DATA_W / 8;

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;

    modport master (output valid, output data, output keep, output last, input ready);
    modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/axis_pkt_echo.sv
// Store-and-forward AXI-stream packet echo: buffers up to DEPTH beats, then replays them.
// Define AXIS_PKT_ECHO_DROP_CNT_EN to add a saturating 16-bit drop_count output.
module axis_pkt_echo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int KEEP_W = DATA_W / 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    axis_pkt_echo_if.slave   r,
    axis_pkt_echo_if.master  t,
    output logic             busy,
    output logic [LEN_W-1:0] pkt_len,
    output logic             overflow
`ifdef AXIS_PKT_ECHO_DROP_CNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    typedef enum logic [1:0] {RECV, SEND, DROP} state_t;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
    logic               overflow_q, overflow_d;
    logic               wr_en;
    logic               t_last_int;

    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [KEEP_W-1:0]  keep_mem [DEPTH];

    // Handshake outputs come from the state register alone so neither side sees a combinational path.
    assign r.ready    = (state_q != SEND);
    assign t.valid    = (state_q == SEND);
    assign t.data     = data_mem[rd_ptr_q];
    assign t.keep     = keep_mem[rd_ptr_q];
    assign t_last_int = (state_q == SEND) && (LEN_W'(rd_ptr_q) == pkt_len_q - LEN_W'(1));
    assign t.last     = t_last_int;

    assign busy     = (state_q != RECV);
    assign pkt_len  = pkt_len_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pkt_len_d  = pkt_len_q;
        overflow_d = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            RECV: begin
                if (r.valid) begin
                    wr_en = 1'b1;
                    if (r.last) begin
                        pkt_len_d = LEN_W'(wr_ptr_q) + LEN_W'(1);
                        rd_ptr_d  = '0;
                        state_d   = SEND;
                    end else if (wr_ptr_q == LAST_PTR) begin
                        state_d = DROP;
                    end else begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                end
            end
            DROP: begin
                if (r.valid && r.last) begin
                    overflow_d = 1'b1;
                    wr_ptr_d   = '0;
                    state_d    = RECV;
                end
            end
            SEND: begin
                if (t.ready) begin
                    if (t_last_int) begin
                        wr_ptr_d  = '0;
                        rd_ptr_d  = '0;
                        pkt_len_d = '0;
                        state_d   = RECV;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RECV;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_len_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_len_q  <= pkt_len_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer contents need no reset; pkt_len gates what is ever read back.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_q] <= r.data;
            keep_mem[wr_ptr_q] <= r.keep;
        end
    end

`ifdef AXIS_PKT_ECHO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (overflow_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
